// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// mem_arbiter_2p : shares one single-port memory between fetch (I) and load/store (D)
// Optional: ARB_ROUND_ROBIN_EN (alternate grants on contention)  -- Revision 1.0
// ============================================================================
module mem_arbiter_2p #(
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  generate
    if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_lat
      $error("mem_arbiter_2p: RD_LAT must be 0..3");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // WAIT ends after RD_LAT cycles; the counter runs 0..RD_LAT-1.
  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_t     state;
  logic       win_d;
  logic       we_q;
  logic [1:0] wait_cnt;
  logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb begin
    grant_d = d_req;
    if (d_req && i_req) begin
      grant_d = ~last_d;
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Gated by rst so a write caught in ACCESS never reaches the memory.
  assign mem_we = we_q & ~rst;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win_d    <= 1'b0;
      we_q     <= 1'b0;
      wait_cnt <= 2'd0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d   <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            win_d    <= grant_d;
            mem_addr <= grant_d ? d_addr : i_addr;
            if (grant_d) begin
              mem_din <= d_wdata;
            end
            we_q  <= grant_d & d_we;
            state <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
            last_d <= grant_d;
`endif
          end
        end
        ACCESS: begin
          we_q     <= 1'b0;
          wait_cnt <= 2'd0;
          if (we_q) begin
            state <= RESP;
            d_ack <= win_d;
            i_ack <= ~win_d;
          end else if (RD_LAT == 0) begin
            if (win_d) d_rdata <= mem_dout;
            else       i_rdata <= mem_dout;
            state <= RESP;
            d_ack <= win_d;
            i_ack <= ~win_d;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            if (win_d) d_rdata <= mem_dout;
            else       i_rdata <= mem_dout;
            state <= RESP;
            d_ack <= win_d;
            i_ack <= ~win_d;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
